// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the decode->execute hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned NumRegs  = 32;
    localparam int unsigned CntWidth = 2;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StRedirect
    } hz_state_t;

    typedef struct packed {
        logic stallF;
        logic stallD;
        logic flushD;
        logic flushE;
    } hazard_ctl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/writeback/memory status in, issue and pipeline-register controls out.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic       d_valid;
    creg_addr_t d_ra1;
    creg_addr_t d_ra2;
    creg_addr_t d_rd;
    logic       d_wen;
    logic       d_is_load;
    logic       wb_valid;
    creg_addr_t wb_rd;
    logic       mem_busy;
    logic       br_taken;

    logic       issue;
    logic       stallF;
    logic       stallD;
    logic       flushD;
    logic       flushE;

    modport master (
        output d_valid, d_ra1, d_ra2, d_rd, d_wen, d_is_load,
        output wb_valid, wb_rd, mem_busy, br_taken,
        input  issue, stallF, stallD, flushD, flushE
    );

    modport slave (
        input  d_valid, d_ra1, d_ra2, d_rd, d_wen, d_is_load,
        input  wb_valid, wb_rd, mem_busy, br_taken,
        output issue, stallF, stallD, flushD, flushE
    );

endinterface

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// Per-register in-flight writer counters with three status read ports.
// HAZARD_FWD_EN: writeback only decrements registers that have a tracked writer.
module hazard_ctrl_reg_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NReg = NumRegs,
    parameter int unsigned CntW = CntWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             incEn,
    input  creg_addr_t       incAddr,
    input  logic             decEn,
    input  creg_addr_t       decAddr,
    input  creg_addr_t [2:0] rdAddr,
    output logic [2:0]       pending,
    output logic [2:0]       saturated
);

    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

    logic [CntW-1:0] cntQ [NReg];
    logic [CntW-1:0] cntD [NReg];
    logic [NReg-1:0] incHit;
    logic [NReg-1:0] decHit;
    logic            decEff;

    // Qualify the decrement; with forwarding, untracked writers also retire here.
    always_comb begin
`ifdef HAZARD_FWD_EN
        decEff = decEn && (cntQ[decAddr] != '0);
`else
        decEff = decEn;
`endif
    end

    // Per-entry next count; simultaneous inc and dec cancel. Entry 0 never moves.
    always_comb begin
        for (int i = 0; i < NReg; i++) begin
            incHit[i] = incEn && (incAddr == creg_addr_t'(i)) && (i != 0);
            decHit[i] = decEff && (decAddr == creg_addr_t'(i)) && (i != 0);
            cntD[i]   = cntQ[i];
            if (incHit[i] && !decHit[i]) begin
                cntD[i] = cntQ[i] + CntOne;
            end else if (decHit[i] && !incHit[i]) begin
                cntD[i] = cntQ[i] - CntOne;
            end
        end
    end

    // Counter array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NReg; i++) begin
                cntQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NReg; i++) begin
                cntQ[i] <= cntD[i];
            end
        end
    end

    // Read ports: pending ignores x0, saturated flags a full counter.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            pending[p]   = (cntQ[rdAddr[p]] != '0) && (rdAddr[p] != '0);
            saturated[p] = (cntQ[rdAddr[p]] == CntMax);
        end
    end

`ifndef HAZARD_FWD_EN
    // A retire with no tracked writer means the scoreboard lost a writer.
    assert property (@(posedge clk) disable iff (reset)
        !(decEn && (decAddr != '0) && (cntQ[decAddr] == '0)));
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Decode->execute scheduler: issue decision, stall/flush controls, memory-wait and
// branch-redirect sequencing. HAZARD_FWD_EN: only loads are tracked by the scoreboard.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    hz_state_t        stateQ, stateD;
    logic             brPendQ, brPendD;
    logic             issueRaw;
    hazard_ctl_t      ctl;
    logic             trackWr;
    logic             hz;
    creg_addr_t [2:0] rdAddr;
    logic [2:0]       pending;
    logic [2:0]       saturated;
    logic             unusedSig;

    assign rdAddr = {bus.d_rd, bus.d_ra2, bus.d_ra1};

`ifdef HAZARD_FWD_EN
    assign trackWr = bus.d_wen & bus.d_is_load;
`else
    assign trackWr = bus.d_wen;
`endif

    // Sources with writers in flight, or a destination whose counter cannot grow.
    assign hz = pending[0] | pending[1] | (trackWr & saturated[2]);

    assign unusedSig = ^{bus.d_is_load, pending[2], saturated[1:0]};

    hazard_ctrl_reg_scoreboard #(
        .NReg (NumRegs),
        .CntW (CntWidth)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .incEn     (issueRaw & trackWr),
        .incAddr   (bus.d_rd),
        .decEn     (bus.wb_valid),
        .decAddr   (bus.wb_rd),
        .rdAddr    (rdAddr),
        .pending   (pending),
        .saturated (saturated)
    );

    // Next state and pipeline controls.
    always_comb begin
        stateD   = stateQ;
        brPendD  = brPendQ;
        issueRaw = 1'b0;
        ctl      = '0;
        unique case (stateQ)
            StRun: begin
                if (bus.br_taken) begin
                    ctl.flushD = 1'b1;
                    ctl.flushE = 1'b1;
                    stateD     = StRedirect;
                end else begin
                    issueRaw = bus.d_valid & ~hz & ~bus.mem_busy;
                    if (bus.d_valid && !issueRaw) begin
                        ctl.stallF = 1'b1;
                        ctl.stallD = 1'b1;
                        ctl.flushE = 1'b1;
                    end
                    if (bus.mem_busy) begin
                        stateD = StMemWait;
                    end
                end
            end
            StMemWait: begin
                // Execute register is held by the memory stage, so no bubble here.
                ctl.stallF = 1'b1;
                ctl.stallD = 1'b1;
                if (bus.br_taken) begin
                    brPendD = 1'b1;
                end
                if (!bus.mem_busy) begin
                    stateD  = (brPendQ || bus.br_taken) ? StRedirect : StRun;
                    brPendD = 1'b0;
                end
            end
            StRedirect: begin
                ctl.flushD = 1'b1;
                stateD     = StRun;
            end
            default: begin
                stateD = StRun;
            end
        endcase
    end

    // FSM state and deferred-branch flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ  <= StRun;
            brPendQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            brPendQ <= brPendD;
        end
    end

    // Outputs are forced low for the whole time reset is held.
    assign bus.issue  = issueRaw & ~reset;
    assign bus.stallF = ctl.stallF & ~reset;
    assign bus.stallD = ctl.stallD & ~reset;
    assign bus.flushD = ctl.flushD & ~reset;
    assign bus.flushE = ctl.flushE & ~reset;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Output vector order: {issue, stallF, stallD, flushD, flushE}.
// HAZARD_FWD_EN selects the forwarding scenario.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [4:0] Idle     = 5'b00000;
    localparam logic [4:0] Issue    = 5'b10000;
    localparam logic [4:0] Bubble   = 5'b01101;
    localparam logic [4:0] MemStall = 5'b01100;
    localparam logic [4:0] Redirect = 5'b00010;
    localparam logic [4:0] Branch   = 5'b00011;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkEq(string tag, logic [4:0] got, logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.issue, bus.stallF, bus.stallD, bus.flushD, bus.flushE};
    endfunction

    task automatic setDec(logic v, creg_addr_t ra1, creg_addr_t ra2, creg_addr_t rd,
                          logic wen, logic ld);
        bus.d_valid   = v;
        bus.d_ra1     = ra1;
        bus.d_ra2     = ra2;
        bus.d_rd      = rd;
        bus.d_wen     = wen;
        bus.d_is_load = ld;
    endtask

    task automatic setWb(logic v, creg_addr_t rd);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
    endtask

    // Inputs are applied just after a falling edge; check, then move to the next one.
    task automatic stepCheck(string tag, logic [4:0] exp);
        #1;
        checkEq(tag, outs(), exp);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.mem_busy = 1'b0;
        bus.br_taken = 1'b0;
        setWb(1'b0, 5'd0);
        setDec(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        #2;
        checkEq("reset_outputs", outs(), Idle);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // RAW: x5 producer, then x6 <= x5 + 1 waits for writeback of x5
        setDec(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        stepCheck("raw_producer", Issue);
        setDec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) stepCheck("raw_stall", Bubble);
        setWb(1'b1, 5'd5);
        stepCheck("raw_wb_same_cycle", Bubble);
        setWb(1'b0, 5'd0);
        stepCheck("raw_issue_after_wb", Issue);
        setDec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        setWb(1'b1, 5'd6);
        stepCheck("idle_wb6", Idle);
        setWb(1'b0, 5'd0);

        // x0 is never pending
        setDec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        stepCheck("x0_write_a", Issue);
        stepCheck("x0_write_b", Issue);
        setDec(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        stepCheck("x0_read", Issue);

        // WAW saturation on x7 with a 2-bit counter
        setDec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) stepCheck("waw_issue", Issue);
        stepCheck("waw_saturated", Bubble);
        setWb(1'b1, 5'd7);
        stepCheck("waw_sat_wb_cycle", Bubble);
        setWb(1'b0, 5'd0);
        stepCheck("waw_after_wb", Issue);
        setDec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        setWb(1'b1, 5'd7);
        for (int i = 0; i < 3; i++) stepCheck("waw_drain", Idle);
        setWb(1'b0, 5'd0);
        setDec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        stepCheck("waw_x7_clear", Issue);

        // Same-cycle inc and dec on x9 leave the count at 1
        setDec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        stepCheck("same_first", Issue);
        setWb(1'b1, 5'd9);
        stepCheck("same_inc_dec", Issue);
        setWb(1'b0, 5'd0);
        setDec(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        stepCheck("same_x9_pending", Bubble);
        setDec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        setWb(1'b1, 5'd9);
        stepCheck("same_wb9", Idle);
        setWb(1'b0, 5'd0);
        setDec(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        stepCheck("same_x9_clear", Issue);

        // Memory wait with a branch arriving mid-wait
        setDec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.mem_busy = 1'b1;
        stepCheck("mem_enter", Idle);
        bus.br_taken = 1'b1;
        stepCheck("mem_wait_br", MemStall);
        bus.br_taken = 1'b0;
        stepCheck("mem_wait_3", MemStall);
        stepCheck("mem_wait_4", MemStall);
        bus.mem_busy = 1'b0;
        stepCheck("mem_exit", MemStall);
        stepCheck("mem_redirect", Redirect);
        stepCheck("mem_back_run", Idle);

        // Taken branch in RUN
        setDec(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        bus.br_taken = 1'b1;
        stepCheck("br_run", Branch);
        bus.br_taken = 1'b0;
        setDec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        stepCheck("br_redirect", Redirect);
        stepCheck("br_back_run", Idle);

        // Reset asserted while in MEM_WAIT with x10 pending
        setDec(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
        stepCheck("rst_x10_issue", Issue);
        setDec(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.mem_busy = 1'b1;
        stepCheck("rst_mem_rise_valid", Bubble);
        #1;
        checkEq("rst_in_mem_wait", outs(), MemStall);
        #2;
        reset = 1'b1;
        #1;
        checkEq("rst_async_outputs", outs(), Idle);
        @(negedge clk);
        reset        = 1'b0;
        bus.mem_busy = 1'b0;
        setDec(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
        stepCheck("rst_cleared", Issue);

`ifdef HAZARD_FWD_EN
        setDec(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
        stepCheck("fwd_alu", Issue);
        setDec(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0);
        stepCheck("fwd_alu_dep", Issue);
        setDec(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
        stepCheck("fwd_load", Issue);
        setDec(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0);
        stepCheck("fwd_load_dep", Bubble);
        setWb(1'b1, 5'd12);
        stepCheck("fwd_load_wb_cycle", Bubble);
        setWb(1'b1, 5'd11);
        stepCheck("fwd_load_clear", Issue);
        setWb(1'b0, 5'd0);
        setDec(1'b1, 5'd11, 5'd12, 5'd0, 1'b0, 1'b0);
        stepCheck("fwd_untracked_wb", Issue);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
